sobel_filter: RTL and testbench
===============================

Name: sobel_filter

Overview:
- AXI4-Stream stage that sits directly downstream of the 3x3 window line buffer.
- Consumes one 72-bit 3x3 greyscale window per beat and computes the Sobel gradient magnitude |Gx|+|Gy|.
- Emits one 24-bit grey pixel (R=G=B) per beat to the video output path.
- Three-stage pipeline with per-stage bubble-collapsing handshake, tuser/tlast propagation, optional threshold and border blanking.

Parameters:
- THRESH_EN, 0: 1 = binary output (255 if magnitude >= THRESHOLD, else 0); 0 = saturated magnitude.
- THRESHOLD, 8'd64: binary threshold, 8-bit unsigned.
- BORDER_ZERO, 1: 1 = force output 0 for windows not fully inside the frame.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  72  window; pixel p[r][c] = s_axis_tdata[24*r+8*c +: 8], r,c in 0..2.
- s_axis_tvalid  in  1  window valid.
- s_axis_tready  out  1  stage 1 can accept.
- s_axis_tuser  in  1  start of frame, first window of frame.
- s_axis_tlast  in  1  last window of line.
- m_axis_tdata  out  24  {mag,mag,mag}.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  delayed s_axis_tuser.
- m_axis_tlast  out  1  delayed s_axis_tlast.

Behaviour:
- Reset (async assert, sync release): all stage valids, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata = 0. Row/column counters = 0. Data registers in flight are discarded.
- Handshake:
  - Stage k holds valid v_k. rdy_k = ~v_k | rdy_(k+1); rdy_4 = m_axis_tready.
  - s_axis_tready = rdy_1.
  - Transfer occurs on tvalid & tready. Stage k loads when rdy_k. v_k <= previous stage's valid on load.
  - Output is stable while m_axis_tvalid & ~m_axis_tready.
  - No beat is lost or duplicated. Bubbles collapse.
- S1 (accept):
  - Column sums CL = p00+2p10+p20 and CR = p02+2p12+p22.
  - Row sums RB = p00+2p01+p02 and RT = p20+2p21+p22.
  - Each sum is 10-bit unsigned, max 1020.
  - Capture tuser, tlast and border flag.
- S2: Gx = CR-CL and Gy = RT-RB as 11-bit signed. |Gx| and |Gy| are 10-bit unsigned.
- S3: mag = |Gx|+|Gy|, 11-bit, max 2040.
  - THRESH_EN=0: out = min(mag,255).
  - THRESH_EN=1: out = (mag >= THRESHOLD) ? 255 : 0.
  - Border flag set and BORDER_ZERO=1: out = 0.
- Latency: 3 cycles from accepted input beat to m_axis_tvalid when never stalled. Throughput is 1 beat/cycle.
- Border tracking (counts accepted input beats only):
  - col_cnt is a 2-bit saturating counter (0,1,2). row_cnt is a 2-bit saturating counter.
  - tuser beat: col_cnt and row_cnt are treated as 0 for that beat. After it, col_cnt = 1 and row_cnt = 0.
  - tlast beat: after it, col_cnt = 0 and row_cnt = sat(row_cnt+1).
  - tuser and tlast on the same beat: counters end with col_cnt = 0 and row_cnt = 1.
  - Border flag = (col_cnt < 2) | (row_cnt < 2), evaluated before the update for that beat.
- Windows with tvalid low are ignored by the counters. Counters saturate at 2 and do not wrap.
- Reset mid-frame: counters clear. The first beat after release is treated as row 0, col 0 until tuser is seen.

Test Plan:
- Uniform window, all pixels 100, BORDER_ZERO=0 -> m_axis_tdata = 24'h000000, valid exactly 3 cycles after accept.
- Column 0 = 0, column 1 = 0, column 2 = 10, rows identical -> Gx=40, Gy=0, m_axis_tdata = 24'h282828. With THRESH_EN=1, THRESHOLD=50 -> 24'h000000.
- Column 0 = 0, column 2 = 255 -> mag 1020, saturates to 24'hFFFFFF. Transpose (row 2 = 255, row 0 = 0) -> 24'hFFFFFF.
- Stream 8 beats with m_axis_tready low for cycles 2-6:
  - s_axis_tready drops once 3 beats are held.
  - All 8 outputs appear in order with no loss.
  - tuser on beat 0 and tlast on beat 7 are preserved on the matching output beats.
- BORDER_ZERO=1, frame of 4 lines x 4 windows, all windows with vertical-edge value 255 -> output is 0 for lines 0-1 and for columns 0-1 of lines 2-3. Output is 255 for the remaining 4 beats.
- Assert aresetn low with 2 beats in flight -> m_axis_tvalid = 0 immediately. After release, only newly accepted beats appear.

Source files
------------

// File: rtl/sobel_filter.sv
// Sobel gradient magnitude |Gx|+|Gy| over a 3x3 greyscale window.
// Three register stages with bubble-collapsing valid/ready, grey RGB out.
module sobel_filter #(
    parameter logic       THRESH_EN   = 1'b0,
    parameter logic [7:0] THRESHOLD   = 8'd64,
    parameter logic       BORDER_ZERO = 1'b1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [71:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast
);

    function automatic logic [9:0] wsum(input logic [7:0] a, b, c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [9:0] absdiff(input logic [9:0] x, y);
        logic [10:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[10] ? (~d[9:0] + 10'd1) : d[9:0];
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] x);
        return (x == 2'd2) ? 2'd2 : x + 2'd1;
    endfunction

    logic [7:0] p [3][3];
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign p[r][c] = s_axis_tdata[24*r+8*c +: 8];
        end
    end

    logic v1, v2;
    logic rdy1, rdy2, rdy3;
    logic accept;

    assign rdy3          = ~m_axis_tvalid | m_axis_tready;
    assign rdy2          = ~v2 | rdy3;
    assign rdy1          = ~v1 | rdy2;
    assign s_axis_tready = rdy1;
    assign accept        = s_axis_tvalid & rdy1;

    // A tuser beat restarts the frame, so it sees zeroed counters
    logic [1:0] col_cnt, row_cnt;
    logic [1:0] eff_col, eff_row;
    logic       border;

    assign eff_col = s_axis_tuser ? 2'd0 : col_cnt;
    assign eff_row = s_axis_tuser ? 2'd0 : row_cnt;
    assign border  = (eff_col < 2'd2) | (eff_row < 2'd2);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            col_cnt <= 2'd0;
            row_cnt <= 2'd0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                col_cnt <= 2'd0;
                row_cnt <= sat_inc(eff_row);
            end else begin
                col_cnt <= sat_inc(eff_col);
                row_cnt <= eff_row;
            end
        end
    end

    logic [9:0] cl, cr, rb, rt;
    logic       u1, l1, b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v1 <= 1'b0;
            cl <= '0;
            cr <= '0;
            rb <= '0;
            rt <= '0;
            u1 <= 1'b0;
            l1 <= 1'b0;
            b1 <= 1'b0;
        end else if (rdy1) begin
            v1 <= s_axis_tvalid;
            cl <= wsum(p[0][0], p[1][0], p[2][0]);
            cr <= wsum(p[0][2], p[1][2], p[2][2]);
            rb <= wsum(p[0][0], p[0][1], p[0][2]);
            rt <= wsum(p[2][0], p[2][1], p[2][2]);
            u1 <= s_axis_tuser;
            l1 <= s_axis_tlast;
            b1 <= border;
        end
    end

    logic [9:0] ax, ay;
    logic       u2, l2, b2;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v2 <= 1'b0;
            ax <= '0;
            ay <= '0;
            u2 <= 1'b0;
            l2 <= 1'b0;
            b2 <= 1'b0;
        end else if (rdy2) begin
            v2 <= v1;
            ax <= absdiff(cr, cl);
            ay <= absdiff(rt, rb);
            u2 <= u1;
            l2 <= l1;
            b2 <= b1;
        end
    end

    logic [10:0] mag;
    logic [7:0]  pix;

    assign mag = {1'b0, ax} + {1'b0, ay};

    always_comb begin
        if (THRESH_EN)
            pix = (mag >= {3'b000, THRESHOLD}) ? 8'hFF : 8'h00;
        else
            pix = (mag > 11'd255) ? 8'hFF : mag[7:0];
        if (BORDER_ZERO && b2)
            pix = 8'h00;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (rdy3) begin
            m_axis_tvalid <= v2;
            m_axis_tdata  <= {pix, pix, pix};
            m_axis_tuser  <= u2;
            m_axis_tlast  <= l2;
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter: saturating, thresholded
// and border-blanking variants driven from one shared input stream.
module tb_sobel_filter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [71:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b1;

    logic        rdy0, rdy1, rdy2;
    logic [23:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        u0, u1, u2;
    logic        l0, l1, l2;

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int out_cnt = 0;

    logic [25:0] q0[$];
    logic [23:0] q1[$];
    logic [23:0] q2[$];

    always #5 clk = ~clk;

    sobel_filter #(.THRESH_EN(1'b0), .THRESHOLD(8'd64), .BORDER_ZERO(1'b0)) dut_sat (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdy0), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(d0), .m_axis_tvalid(v0), .m_axis_tready(m_tready),
        .m_axis_tuser(u0), .m_axis_tlast(l0)
    );

    sobel_filter #(.THRESH_EN(1'b1), .THRESHOLD(8'd50), .BORDER_ZERO(1'b0)) dut_thr (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdy1), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(d1), .m_axis_tvalid(v1), .m_axis_tready(m_tready),
        .m_axis_tuser(u1), .m_axis_tlast(l1)
    );

    sobel_filter #(.THRESH_EN(1'b0), .THRESHOLD(8'd64), .BORDER_ZERO(1'b1)) dut_brd (
        .aclk(clk), .aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(rdy2), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
        .m_axis_tdata(d2), .m_axis_tvalid(v2), .m_axis_tready(m_tready),
        .m_axis_tuser(u2), .m_axis_tlast(l2)
    );

    // Records transfers that will happen on the coming rising edge
    always @(negedge clk) begin
        #1;
        if (s_tvalid && rdy0) acc_cnt++;
        if (v0 && m_tready) begin
            q0.push_back({u0, l0, d0});
            q1.push_back(d1);
            q2.push_back(d2);
            out_cnt++;
        end
    end

    function automatic logic [71:0] cols(input logic [7:0] a, b, c);
        logic [23:0] row;
        row = {c, b, a};
        return {row, row, row};
    endfunction

    function automatic logic [71:0] rows(input logic [7:0] a, b, c);
        return {{3{c}}, {3{b}}, {3{a}}};
    endfunction

    task automatic clear_q;
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic drive_beat(input logic [71:0] d, input logic u, input logic l);
        int t = 0;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (!rdy0 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!rdy0) begin
            tests++;
            fails++;
            $display("FAIL drive_timeout: s_axis_tready=%b required 1", rdy0);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        int t = 0;
        while (q0.size() < n && t < 80) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        ok = (q0.size() == n);
    endtask

    task automatic send_get(input logic [71:0] d, output bit ok);
        clear_q();
        m_tready = 1'b1;
        drive_beat(d, 1'b0, 1'b0);
        wait_out(1, ok);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({v0, u0, l0, d0} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", {v0, u0, l0, d0});
        end
        tests++;
        if (rdy0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_tready: got %b required 1", rdy0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (v0 !== 1'b0) begin
            fails++;
            $display("FAIL post_release_valid: got %b required 0", v0);
        end
        @(negedge clk);
    endtask

    task automatic test_latency;
        clear_q();
        m_tready = 1'b1;
        s_tdata  = {9{8'd100}};
        s_tvalid = 1'b1;
        #1;
        tests++;
        if (rdy0 !== 1'b1) begin
            fails++;
            $display("FAIL lat_accept: s_axis_tready=%b required 1", rdy0);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        #2;
        tests++;
        if (v0 !== 1'b0) begin
            fails++;
            $display("FAIL lat_cycle1: valid=%b required 0", v0);
        end
        @(negedge clk);
        #2;
        tests++;
        if (v0 !== 1'b0) begin
            fails++;
            $display("FAIL lat_cycle2: valid=%b required 0", v0);
        end
        @(negedge clk);
        #2;
        tests++;
        if (v0 !== 1'b1 || d0 !== 24'h000000) begin
            fails++;
            $display("FAIL lat_cycle3: valid=%b data=%h required 1 000000", v0, d0);
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gradient;
        logic [71:0] w [6];
        logic [23:0] e [6];
        bit ok;
        w[0] = cols(8'd0, 8'd0, 8'd10);      e[0] = 24'h282828;
        w[1] = cols(8'd10, 8'd0, 8'd0);      e[1] = 24'h282828;
        w[2] = rows(8'd0, 8'd0, 8'd10);      e[2] = 24'h282828;
        w[3] = rows(8'd10, 8'd7, 8'd0);      e[3] = 24'h282828;
        w[4] = {8'd10, 64'd0};               e[4] = 24'h141414;
        w[5] = {48'd0, 8'd30, 16'd0};        e[5] = 24'h3C3C3C;
        for (int i = 0; i < 6; i++) begin
            send_get(w[i], ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL grad_count[%0d]: beats=%0d required 1", i, q0.size());
            end else if (q0[0][23:0] !== e[i]) begin
                fails++;
                $display("FAIL grad_data[%0d]: got %h required %h", i, q0[0][23:0], e[i]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [71:0] w [5];
        logic [23:0] e [5];
        bit ok;
        w[0] = {8'd127, 64'd0};                e[0] = 24'hFEFEFE;
        w[1] = {8'd128, 64'd0};                e[1] = 24'hFFFFFF;
        w[2] = cols(8'd0, 8'd0, 8'd255);       e[2] = 24'hFFFFFF;
        w[3] = cols(8'd255, 8'd0, 8'd0);       e[3] = 24'hFFFFFF;
        w[4] = rows(8'd0, 8'd128, 8'd255);     e[4] = 24'hFFFFFF;
        for (int i = 0; i < 5; i++) begin
            send_get(w[i], ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL sat_count[%0d]: beats=%0d required 1", i, q0.size());
            end else if (q0[0][23:0] !== e[i]) begin
                fails++;
                $display("FAIL sat_data[%0d]: got %h required %h", i, q0[0][23:0], e[i]);
            end
        end
    endtask

    task automatic test_threshold;
        logic [71:0] w [4];
        logic [23:0] e [4];
        bit ok;
        w[0] = cols(8'd0, 8'd0, 8'd10);   e[0] = 24'h000000;
        w[1] = {8'd25, 64'd0};            e[1] = 24'hFFFFFF;
        w[2] = {8'd24, 64'd0};            e[2] = 24'h000000;
        w[3] = cols(8'd0, 8'd0, 8'd255);  e[3] = 24'hFFFFFF;
        for (int i = 0; i < 4; i++) begin
            send_get(w[i], ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL thr_count[%0d]: beats=%0d required 1", i, q1.size());
            end else if (q1[0] !== e[i]) begin
                fails++;
                $display("FAIL thr_data[%0d]: got %h required %h", i, q1[0], e[i]);
            end
        end
    endtask

    task automatic test_stall;
        bit ok;
        bit seen_drop = 1'b0;
        int held = -1;
        logic [7:0] eb;
        clear_q();
        acc_cnt = 0;
        out_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat(cols(8'd0, 8'd0, 8'(5*i+1)), i == 0, i == 7);
            end
            begin
                m_tready = 1'b1;
                repeat (2) @(negedge clk);
                m_tready = 1'b0;
                repeat (5) @(negedge clk);
                m_tready = 1'b1;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    #2;
                    if (!rdy0 && !seen_drop) begin
                        seen_drop = 1'b1;
                        held = acc_cnt - out_cnt;
                    end
                    @(negedge clk);
                end
            end
        join
        wait_out(8, ok);
        tests++;
        if (!seen_drop || held != 3) begin
            fails++;
            $display("FAIL stall_backpressure: dropped=%b held=%0d required 1 3", seen_drop, held);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_count: beats=%0d required 8", q0.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                eb = 8'(4 * (5*i + 1));
                tests++;
                if (q0[i] !== {i == 0, i == 7, eb, eb, eb}) begin
                    fails++;
                    $display("FAIL stall_beat[%0d]: got %h required %h", i, q0[i], {i == 0, i == 7, eb, eb, eb});
                end
            end
        end
    endtask

    task automatic test_border;
        bit ok;
        logic [23:0] e;
        clear_q();
        m_tready = 1'b1;
        for (int ln = 0; ln < 4; ln++)
            for (int c = 0; c < 4; c++)
                drive_beat(cols(8'd0, 8'd0, 8'd255), ln == 0 && c == 0, c == 3);
        wait_out(16, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL border_count: beats=%0d required 16", q2.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = (i / 4 >= 2 && i % 4 >= 2) ? 24'hFFFFFF : 24'h000000;
                tests++;
                if (q2[i] !== e) begin
                    fails++;
                    $display("FAIL border_beat[%0d]: got %h required %h", i, q2[i], e);
                end
            end
        end
    endtask

    task automatic test_user_last;
        bit ok;
        logic [23:0] e;
        logic [1:0] ul [5];
        ul[0] = 2'b11;
        ul[1] = 2'b01;
        ul[2] = 2'b00;
        ul[3] = 2'b00;
        ul[4] = 2'b00;
        clear_q();
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++)
            drive_beat(cols(8'd0, 8'd0, 8'd255), ul[i][1], ul[i][0]);
        wait_out(5, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL ul_count: beats=%0d required 5", q2.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                e = (i == 4) ? 24'hFFFFFF : 24'h000000;
                tests++;
                if (q2[i] !== e) begin
                    fails++;
                    $display("FAIL ul_beat[%0d]: got %h required %h", i, q2[i], e);
                end
            end
        end
    endtask

    task automatic test_reset_flight;
        bit ok;
        clear_q();
        m_tready = 1'b0;
        drive_beat(cols(8'd0, 8'd0, 8'd10), 1'b0, 1'b0);
        drive_beat(cols(8'd0, 8'd0, 8'd20), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        tests++;
        if (v0 !== 1'b1) begin
            fails++;
            $display("FAIL rst_precond: valid=%b required 1", v0);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (v0 !== 1'b0 || d0 !== 24'h0) begin
            fails++;
            $display("FAIL rst_immediate: valid=%b data=%h required 0 000000", v0, d0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_q();
        m_tready = 1'b1;
        drive_beat(cols(8'd0, 8'd0, 8'd3), 1'b0, 1'b0);
        wait_out(1, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_flush: beats=%0d required 1", q0.size());
        end else if (q0[0][23:0] !== 24'h0C0C0C) begin
            fails++;
            $display("FAIL rst_new_beat: got %h required 0c0c0c", q0[0][23:0]);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_gradient();
        test_saturation();
        test_threshold();
        test_stall();
        test_border();
        test_user_last();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
